// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: mono I2S transmitter for the WM8731 DAC.
// Generates BCLK/DACLRCK from the system clock and requests one sample per frame
// with data_over. It captures the sample mid-frame and emits it on both channels
// of the following frame.
module audio_i2s_tx #(
    parameter int unsigned BCLK_DIV = 8,
    parameter int unsigned ATTEN    = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] sample_in,
    input  logic        mute,
    output logic        data_over,
    output logic        AUD_BCLK,
    output logic        AUD_DACLRCK,
    output logic        AUD_DACDAT
);

    localparam int unsigned DivW = $clog2(BCLK_DIV);

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [5:0]      bit_cnt_q, bit_cnt_d;
    logic [15:0]     held_q, held_d;
    logic [15:0]     frame_q, frame_d;
    logic            bclk_q, bclk_d;
    logic            lrck_q, lrck_d;
    logic            dat_q, dat_d;
    logic            data_over_q, data_over_d;

    logic            div_wrap;
    logic            fall_evt;
    logic [5:0]      bit_cnt_inc;
    logic [4:0]      slot;
    logic [3:0]      slot_idx;
    logic            slot_has_data;
    logic signed [15:0] sample_s;
    logic [15:0]     sample_att;

    assign div_wrap      = (div_cnt_q == DivW'(BCLK_DIV - 1));
    // All serial state moves on the BCLK falling edge so the DAC sees stable data
    // on the rising edge.
    assign fall_evt      = div_wrap & bclk_q;
    assign bit_cnt_inc   = bit_cnt_q + 6'd1;
    assign slot          = bit_cnt_inc[4:0];
    // Slot 0 carries the I2S one-bit delay; MSB goes out in slot 1.
    assign slot_has_data = (slot != 5'd0) && (slot <= 5'd16);
    assign slot_idx      = 4'(5'd16 - slot);
    assign sample_s      = sample_in;
    assign sample_att    = 16'(sample_s >>> ATTEN);

    // Next-state logic for the divider, bit counter and serialiser.
    always_comb begin
        div_cnt_d   = div_wrap ? '0 : div_cnt_q + DivW'(1);
        bclk_d      = div_wrap ? ~bclk_q : bclk_q;
        bit_cnt_d   = bit_cnt_q;
        lrck_d      = lrck_q;
        dat_d       = dat_q;
        frame_d     = frame_q;
        held_d      = held_q;
        data_over_d = 1'b0;
        if (fall_evt) begin
            bit_cnt_d = bit_cnt_inc;
            lrck_d    = bit_cnt_inc[5];
            dat_d     = slot_has_data ? frame_q[slot_idx] : 1'b0;
            // Frame start: latch the word for both channels and request the next one.
            if (bit_cnt_inc == 6'd0) begin
                frame_d     = held_q;
                data_over_d = 1'b1;
            end
            // Mid-frame capture gives upstream half a frame to settle after data_over.
            if (bit_cnt_inc == 6'd32) begin
                held_d = mute ? 16'h0000 : sample_att;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            div_cnt_q   <= '0;
            bit_cnt_q   <= 6'd63;
            held_q      <= 16'h0000;
            frame_q     <= 16'h0000;
            bclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            dat_q       <= 1'b0;
            data_over_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            held_q      <= held_d;
            frame_q     <= frame_d;
            bclk_q      <= bclk_d;
            lrck_q      <= lrck_d;
            dat_q       <= dat_d;
            data_over_q <= data_over_d;
        end
    end

    assign data_over   = data_over_q;
    assign AUD_BCLK    = bclk_q;
    assign AUD_DACLRCK = lrck_q;
    assign AUD_DACDAT  = dat_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: scoreboard bench for audio_i2s_tx.
// Two instances (ATTEN=0 and ATTEN=2) share the stimulus. An I2S receiver model
// deserialises each channel and checks it against the queued expected words.
module tb_audio_i2s_tx;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] sample_in = 16'h0000;
    logic        mute = 1'b0;

    logic dov0, bclk0, lrck0, dat0;
    logic dov1, bclk1, lrck1, dat1;
    logic [1:0] dov_v, bclk_v, lrck_v, dat_v;

    assign dov_v  = {dov1, dov0};
    assign bclk_v = {bclk1, bclk0};
    assign lrck_v = {lrck1, lrck0};
    assign dat_v  = {dat1, dat0};

    audio_i2s_tx #(.BCLK_DIV(8), .ATTEN(0)) u_dut0 (
        .Clk        (Clk),
        .Reset      (Reset),
        .sample_in  (sample_in),
        .mute       (mute),
        .data_over  (dov0),
        .AUD_BCLK   (bclk0),
        .AUD_DACLRCK(lrck0),
        .AUD_DACDAT (dat0)
    );

    audio_i2s_tx #(.BCLK_DIV(8), .ATTEN(2)) u_dut1 (
        .Clk        (Clk),
        .Reset      (Reset),
        .sample_in  (sample_in),
        .mute       (mute),
        .data_over  (dov1),
        .AUD_BCLK   (bclk1),
        .AUD_DACLRCK(lrck1),
        .AUD_DACDAT (dat1)
    );

    always #10 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Clk edges since Reset was last sampled high; 0 while in reset.
    int unsigned cyc = 0;
    logic        run_q = 1'b0;

    always @(posedge Clk) begin
        run_q <= Reset;
        cyc   <= Reset ? cyc + 1 : 0;
    end

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cyc(input int unsigned n);
        int guard = 0;
        while (cyc < n && guard < 20000) begin
            @(negedge Clk);
            guard++;
        end
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc: reached %0d, expected %0d", cyc, n);
        end
    endtask

    // Receiver model: samples on BCLK rising edges, frame position derived from time.
    initial begin
        logic        prev_b[2];
        logic [15:0] word[2];
        logic        junk[2];
        logic        lrbad[2];
        logic [15:0] cur_exp[2];
        logic        have[2];
        for (int i = 0; i < 2; i++) begin
            prev_b[i] = 1'b0; word[i] = '0; junk[i] = 1'b0; lrbad[i] = 1'b0;
            cur_exp[i] = '0; have[i] = 1'b0;
        end
        forever begin
            @(negedge Clk);
            if (!run_q) begin
                for (int i = 0; i < 2; i++) begin
                    prev_b[i] = 1'b0; word[i] = '0; junk[i] = 1'b0; lrbad[i] = 1'b0;
                    have[i] = 1'b0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    logic exp_do;
                    exp_do = (cyc >= 16) && (((cyc - 16) % 1024) == 0);
                    if (exp_do || dov_v[i]) begin
                        check($sformatf("dut%0d data_over", i), 32'(dov_v[i]), 32'(exp_do));
                    end
                    if (!prev_b[i] && bclk_v[i] && cyc >= 24) begin
                        int pos;
                        int s;
                        if (((cyc - 24) % 16) != 0) lrbad[i] = 1'b1;
                        pos = ((int'(cyc) - 24) / 16) % 64;
                        s   = pos % 32;
                        if (lrck_v[i] != (pos >= 32)) lrbad[i] = 1'b1;
                        if (s >= 1 && s <= 16) word[i][16-s] = dat_v[i];
                        else if (dat_v[i]) junk[i] = 1'b1;
                        if (s == 31) begin
                            if (pos == 31) begin
                                if (i == 0 && exp_q0.size() > 0) begin
                                    cur_exp[i] = exp_q0.pop_front(); have[i] = 1'b1;
                                end else if (i == 1 && exp_q1.size() > 0) begin
                                    cur_exp[i] = exp_q1.pop_front(); have[i] = 1'b1;
                                end else begin
                                    have[i] = 1'b0;
                                    check($sformatf("dut%0d expected word available", i), 0, 1);
                                end
                            end
                            if (have[i]) begin
                                check($sformatf("dut%0d %s channel {lrck_err,junk,word}", i,
                                                (pos == 31) ? "left" : "right"),
                                      {14'd0, lrbad[i], junk[i], word[i]},
                                      {14'd0, 1'b0, 1'b0, cur_exp[i]});
                            end
                            word[i] = '0; junk[i] = 1'b0; lrbad[i] = 1'b0;
                        end
                    end
                    prev_b[i] = bclk_v[i];
                end
            end
        end
    end

    // Directed vectors: value/mute at capture, value driven right after capture,
    // expected word for ATTEN=0 and ATTEN=2.
    logic [15:0] v_smp [9] = '{16'hA5C3, 16'h1234, 16'h7FFF, 16'h8000, 16'h7FFF,
                               16'h4001, 16'hFFFF, 16'h00FF, 16'h0F0F};
    logic        v_mute[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] v_junk[9] = '{16'h0000, 16'h7FFF, 16'h1111, 16'h7FFF, 16'h2222,
                               16'h3333, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] v_e0  [9] = '{16'hA5C3, 16'h1234, 16'h7FFF, 16'h8000, 16'h0000,
                               16'h4001, 16'hFFFF, 16'h00FF, 16'h0F0F};
    logic [15:0] v_e1  [9] = '{16'hE970, 16'h048D, 16'h1FFF, 16'hE000, 16'h0000,
                               16'h1000, 16'hFFFF, 16'h003F, 16'h03C3};

    task automatic startup();
        exp_q0.push_back(16'h0000);
        exp_q1.push_back(16'h0000);
        wait_cyc(7);
        check("bclk low at 7", 32'(bclk_v), 32'b00);
        wait_cyc(8);
        check("bclk rises at 8", 32'(bclk_v), 32'b11);
        wait_cyc(15);
        check("bclk high at 15", 32'(bclk_v), 32'b11);
        wait_cyc(16);
        check("bclk falls at 16", 32'(bclk_v), 32'b00);
    endtask

    // Drive vector v so it is stable at capture m, then disturb inputs right after.
    task automatic apply(input int m, input int v);
        int unsigned e;
        e = 528 + 1024 * m;
        wait_cyc(e - 1);
        sample_in = v_smp[v];
        mute      = v_mute[v];
        exp_q0.push_back(v_e0[v]);
        exp_q1.push_back(v_e1[v]);
        wait_cyc(e);
        sample_in = v_junk[v];
        mute      = ~v_mute[v];
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        check("outputs in reset", {24'd0, dov_v, bclk_v, lrck_v, dat_v}, 32'd0);
        repeat (7) @(negedge Clk);
        Reset = 1'b1;
        startup();
        for (int v = 0; v < 8; v++) apply(v, v);

        // Reset in slot 9 of frame 9's left channel, while BCLK and DACDAT are high.
        wait_cyc(8361);
        check("dut0 data before mid-frame reset", {30'd0, bclk0, dat0}, 32'b11);
        Reset = 1'b0;
        @(negedge Clk);
        check("outputs after mid-frame reset", {24'd0, dov_v, bclk_v, lrck_v, dat_v}, 32'd0);
        exp_q0.delete();
        exp_q1.delete();
        repeat (9) @(negedge Clk);
        Reset = 1'b1;
        startup();
        apply(0, 8);
        wait_cyc(2070);
        check("dut0 queue drained", exp_q0.size(), 0);
        check("dut1 queue drained", exp_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
